lfsr_prbs_gen: RTL and testbench
================================

LFSR_PRBS_GEN -- requirements
Module: lfsr_prbs_gen

Interface
REQ-001 SHALL provide parameter WIDTH, default 22, register width in bits (3..64).
REQ-002 SHALL provide parameter TAPS, default 22'h000003, feedback mask; bit k set = state[k] enters XNOR feedback.
REQ-003 SHALL provide parameter BPC, default 1, LFSR sub-steps (output bits) per enabled cycle (1..WIDTH).
REQ-004 SHALL provide parameter DEBRUIJN, default 1, 1 = insert all-ones state into sequence (period 2^WIDTH), 0 = plain maximal-length (period 2^WIDTH-1).
REQ-005 SHALL provide parameter EXT_PRE, default 1, state after which the all-ones state is inserted when DEBRUIJN=1.
REQ-006 SHALL provide parameter RESET_VALUE, default 1, state loaded by reset and by lock-up recovery.
REQ-007 SHALL provide parameter MARK, default all ones, state whose occurrence raises mark.
REQ-008 sys_clk  input  1  sole clock, all logic on rising edge.
REQ-009 reset  input  1  synchronous, active-high reset.
REQ-010 clk_ena  input  1  step enable; one enabled cycle = BPC sub-steps.
REQ-011 load  input  1  synchronous seed load.
REQ-012 seed_in  input  WIDTH  value loaded when load=1.
REQ-013 state_out  output  WIDTH  registered LFSR state.
REQ-014 dout  output  BPC  registered PRBS bits, dout[0] = first bit generated.
REQ-015 dout_valid  output  1  registered, high the cycle after an enabled step.
REQ-016 mark  output  1  registered one-cycle pulse, high when any sub-step of the last step produced MARK.
REQ-017 lockup  output  1  registered one-cycle pulse, high when lock-up recovery occurred on the last step.

Function
REQ-018 Sub-step f(s) SHALL be {fb, s[WIDTH-1:1]} with fb = XNOR-reduction of (s & TAPS); bit shifted out = s[0].
REQ-019 With DEBRUIJN=1 a sub-step SHALL map EXT_PRE -> all ones, all ones -> f(EXT_PRE), every other s -> f(s).
REQ-020 With DEBRUIJN=0 a sub-step from all ones SHALL yield RESET_VALUE and flag lock-up; other s -> f(s).
REQ-021 An enabled cycle SHALL apply BPC chained sub-steps within one clock; state_out updates on that edge (latency 1).
REQ-022 dout[i] SHALL equal bit 0 of the state entering sub-step i.
REQ-023 mark SHALL assert if any sub-step result equals MARK; lockup if any sub-step took the REQ-020 recovery path.
REQ-024 clk_ena=0 and load=0 SHALL hold state_out and dout; dout_valid, mark, lockup go low.
REQ-025 load=1 SHALL set state_out=seed_in, dout_valid=0, mark=0, lockup=0, regardless of clk_ena.
REQ-026 Loading all ones with DEBRUIJN=0 SHALL be accepted; recovery occurs on the next enabled step.
REQ-027 Priority SHALL be reset > load > clk_ena.
REQ-028 TAPS, EXT_PRE on the maximal cycle is the integrator's responsibility; no runtime check.

Reset
REQ-029 reset=1 on a rising edge SHALL set state_out=RESET_VALUE, dout=0, dout_valid=0, mark=0, lockup=0.
REQ-030 Reset asserted mid-step SHALL discard the step; first enabled step after release starts from RESET_VALUE.

Verification
REQ-031 Defaults, reset then 3 enabled cycles -> state_out 0x000001, 0x3FFFFF (mark=1), 0x000000, 0x200000.
REQ-032 Defaults, 4194304 enabled cycles from reset -> state_out returns to 0x000001 exactly once; all states unique over the period.
REQ-033 BPC=4, reset then one enable -> state_out=0x300000, dout=4'b0011, dout_valid=1, mark=1.
REQ-034 DEBRUIJN=0, load seed_in=0x3FFFFF then one enable -> state_out=0x000001, lockup=1 for one cycle.
REQ-035 load=1 with clk_ena=1, seed_in=0x155555 -> state_out=0x155555, dout_valid=0; next enable -> 0x0AAAAA.
REQ-036 clk_ena toggled randomly vs. reference model -> identical state_out/dout sequence, held values while disabled.

Source files
------------

// File: rtl/lfsr_prbs_gen.sv
// Parameterised XNOR LFSR PRBS generator, BPC bits per enabled cycle.
// Optional de Bruijn extension inserts the all-ones state into the cycle.
module lfsr_prbs_gen #(
  parameter int unsigned     WIDTH       = 22,
  parameter logic [WIDTH-1:0] TAPS       = WIDTH'(22'h000003),
  parameter int unsigned     BPC         = 1,
  parameter bit              DEBRUIJN    = 1'b1,
  parameter logic [WIDTH-1:0] EXT_PRE    = WIDTH'(1),
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(1),
  parameter logic [WIDTH-1:0] MARK       = '1
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             clk_ena,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] state_out,
  output logic [BPC-1:0]   dout,
  output logic             dout_valid,
  output logic             mark,
  output logic             lockup
);

  localparam logic [WIDTH-1:0] ONES = '1;

  function automatic logic [WIDTH-1:0] f(input logic [WIDTH-1:0] s);
    return {~^(s & TAPS), s[WIDTH-1:1]};
  endfunction

  logic [WIDTH-1:0] nxt;
  logic [BPC-1:0]   bits;
  logic             hit;
  logic             lk;

  always_comb begin
    nxt  = state_out;
    bits = '0;
    hit  = 1'b0;
    lk   = 1'b0;
    for (int i = 0; i < int'(BPC); i++) begin
      bits[i] = nxt[0];
      if (DEBRUIJN) begin
        // EXT_PRE detours through all-ones, which rejoins at f(EXT_PRE)
        if (nxt == EXT_PRE)   nxt = ONES;
        else if (nxt == ONES) nxt = f(EXT_PRE);
        else                  nxt = f(nxt);
      end else if (nxt == ONES) begin
        nxt = RESET_VALUE;
        lk  = 1'b1;
      end else begin
        nxt = f(nxt);
      end
      if (nxt == MARK) hit = 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_out  <= RESET_VALUE;
      dout       <= '0;
      dout_valid <= 1'b0;
      mark       <= 1'b0;
      lockup     <= 1'b0;
    end else if (load) begin
      state_out  <= seed_in;
      dout_valid <= 1'b0;
      mark       <= 1'b0;
      lockup     <= 1'b0;
    end else if (clk_ena) begin
      state_out  <= nxt;
      dout       <= bits;
      dout_valid <= 1'b1;
      mark       <= hit;
      lockup     <= lk;
    end else begin
      dout_valid <= 1'b0;
      mark       <= 1'b0;
      lockup     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lfsr_prbs_gen.sv
// Directed bench for lfsr_prbs_gen: default, BPC=4, plain LFSR and
// a 4-bit instance for a full-period walk.
module tb_lfsr_prbs_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clk_ena = 1'b0;
  logic        load = 1'b0;
  logic [21:0] seed_in = '0;

  logic [21:0] st, st4, stn;
  logic [3:0]  stw;
  logic [0:0]  dq, dqn, dqw;
  logic [3:0]  dq4;
  logic        dv, dv4, dvn, dvw;
  logic        mk, mk4, mkn, mkw;
  logic        lk, lk4, lkn, lkw;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lfsr_prbs_gen dut (
    .sys_clk(clk), .reset(reset), .clk_ena(clk_ena), .load(load),
    .seed_in(seed_in), .state_out(st), .dout(dq), .dout_valid(dv),
    .mark(mk), .lockup(lk));

  lfsr_prbs_gen #(.BPC(4)) dut4 (
    .sys_clk(clk), .reset(reset), .clk_ena(clk_ena), .load(load),
    .seed_in(seed_in), .state_out(st4), .dout(dq4), .dout_valid(dv4),
    .mark(mk4), .lockup(lk4));

  lfsr_prbs_gen #(.DEBRUIJN(1'b0)) dutn (
    .sys_clk(clk), .reset(reset), .clk_ena(clk_ena), .load(load),
    .seed_in(seed_in), .state_out(stn), .dout(dqn), .dout_valid(dvn),
    .mark(mkn), .lockup(lkn));

  lfsr_prbs_gen #(.WIDTH(4), .TAPS(4'h3)) dutw (
    .sys_clk(clk), .reset(reset), .clk_ena(clk_ena), .load(load),
    .seed_in(seed_in[3:0]), .state_out(stw), .dout(dqw), .dout_valid(dvw),
    .mark(mkw), .lockup(lkw));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; load = 1'b0; clk_ena = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clk_ena = 1'b1;
    do_reset();
    checks++;
    if (st !== 22'h000001) begin
      failures++; $display("FAIL reset_state got=%h exp=000001", st);
    end
    checks++;
    if ({dq4, dv, mk, lk} !== 7'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=0000000", {dq4, dv, mk, lk});
    end
    checks++;
    if (stw !== 4'h1 || dvw !== 1'b0) begin
      failures++; $display("FAIL reset_w4 got=%h/%b exp=1/0", stw, dvw);
    end
  endtask

  task automatic test_sequence();
    do_reset();
    clk_ena = 1'b1;
    tick();
    checks++;
    if ({st, mk, dv, dq} !== {22'h3FFFFF, 3'b111}) begin
      failures++;
      $display("FAIL seq1 got=%h m=%b v=%b d=%b exp=3fffff 1 1 1",
               st, mk, dv, dq);
    end
    tick();
    checks++;
    if ({st, mk, dq} !== {22'h000000, 2'b01}) begin
      failures++;
      $display("FAIL seq2 got=%h m=%b d=%b exp=000000 0 1", st, mk, dq);
    end
    tick();
    checks++;
    if ({st, mk, dq} !== {22'h200000, 2'b00}) begin
      failures++;
      $display("FAIL seq3 got=%h m=%b d=%b exp=200000 0 0", st, mk, dq);
    end
    clk_ena = 1'b0;
  endtask

  task automatic test_bpc4();
    do_reset();
    clk_ena = 1'b1;
    tick();
    clk_ena = 1'b0;
    checks++;
    if (st4 !== 22'h300000) begin
      failures++; $display("FAIL bpc4_state got=%h exp=300000", st4);
    end
    checks++;
    if ({dq4, dv4, mk4} !== 6'b0011_1_1) begin
      failures++;
      $display("FAIL bpc4_out got=%b/%b/%b exp=0011/1/1", dq4, dv4, mk4);
    end
  endtask

  task automatic test_lockup();
    do_reset();
    load = 1'b1; seed_in = 22'h3FFFFF;
    tick();
    load = 1'b0;
    checks++;
    if ({stn, dvn, lkn} !== {22'h3FFFFF, 2'b00}) begin
      failures++;
      $display("FAIL lock_load got=%h v=%b l=%b exp=3fffff 0 0",
               stn, dvn, lkn);
    end
    clk_ena = 1'b1;
    tick();
    clk_ena = 1'b0;
    checks++;
    if ({stn, lkn, dvn} !== {22'h000001, 2'b11}) begin
      failures++;
      $display("FAIL lock_rec got=%h l=%b v=%b exp=000001 1 1",
               stn, lkn, dvn);
    end
    tick();
    checks++;
    if ({stn, lkn} !== {22'h000001, 1'b0}) begin
      failures++; $display("FAIL lock_pulse got=%h l=%b exp=000001 0", stn, lkn);
    end
  endtask

  task automatic test_load();
    do_reset();
    load = 1'b1; clk_ena = 1'b1; seed_in = 22'h155555;
    tick();
    load = 1'b0;
    checks++;
    if ({st, dv, mk} !== {22'h155555, 2'b00}) begin
      failures++;
      $display("FAIL load_pri got=%h v=%b m=%b exp=155555 0 0", st, dv, mk);
    end
    tick();
    clk_ena = 1'b0;
    checks++;
    if ({st, dq, dv} !== {22'h0AAAAA, 2'b11}) begin
      failures++;
      $display("FAIL load_step got=%h d=%b v=%b exp=0aaaaa 1 1", st, dq, dv);
    end
  endtask

  task automatic test_hold();
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if ({st, dq, dv, mk, lk} !== {22'h0AAAAA, 4'b1000}) begin
        failures++;
        $display("FAIL hold%0d got=%h d=%b v=%b exp=0aaaaa 1 0",
                 k, st, dq, dv);
      end
    end
  endtask

  task automatic test_reset_mid();
    clk_ena = 1'b1; reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({st, dv} !== {22'h000001, 1'b0}) begin
      failures++; $display("FAIL rst_mid got=%h v=%b exp=000001 0", st, dv);
    end
    tick();
    clk_ena = 1'b0;
    checks++;
    if (st !== 22'h3FFFFF) begin
      failures++; $display("FAIL rst_mid_step got=%h exp=3fffff", st);
    end
  endtask

  task automatic test_period();
    bit [15:0] seen;
    int ret;
    int uniq;
    seen = '0; ret = 0; uniq = 0;
    do_reset();
    clk_ena = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (!seen[stw]) uniq++;
      seen[stw] = 1'b1;
      if (stw == 4'h1) ret++;
    end
    clk_ena = 1'b0;
    checks++;
    if (uniq !== 16 || ret !== 1 || stw !== 4'h1) begin
      failures++;
      $display("FAIL period_w4 uniq=%0d ret=%0d last=%h exp=16 1 1",
               uniq, ret, stw);
    end
  endtask

  task automatic test_random();
    logic [21:0] m;
    logic        md;
    logic        mm;
    logic        en;
    do_reset();
    m = 22'h000001; md = 1'b0;
    for (int k = 0; k < 300; k++) begin
      en = 1'($urandom_range(0, 1));
      clk_ena = en;
      mm = 1'b0;
      if (en) begin
        md = m[0];
        if (m == 22'h000001)      m = 22'h3FFFFF;
        else if (m == 22'h3FFFFF) m = 22'h000000;
        else                      m = {m[0] == m[1], m[21:1]};
        mm = (m == 22'h3FFFFF);
      end
      tick();
      checks++;
      if ({st, dq, dv, mk} !== {m, md, en, mm}) begin
        failures++;
        $display("FAIL rand%0d got=%h d=%b v=%b m=%b exp=%h %b %b %b",
                 k, st, dq, dv, mk, m, md, en, mm);
      end
    end
    clk_ena = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_bpc4();
    test_lockup();
    test_load();
    test_hold();
    test_reset_mid();
    test_period();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
